// File: rtl/tx_bank_sched.sv
// Banked USB TX buffer scheduler: bank 0 carries handshake replies, banks 1..NDATA carry ADC frames.
// Optional saturating drop counter is enabled by defining TX_BANK_SCHED_OVF_CNT_EN.
module tx_bank_sched #(
   parameter int BADDR_NBIT   = 2,
   parameter int OVF_CNT_NBIT = 16
) (
   input  logic                       mclk,
   input  logic                       rst_n,
   input  logic                       wr_eop,
   input  logic [BADDR_NBIT-1:0]      wr_baddr,
   output logic [BADDR_NBIT-1:0]      wr_next_baddr,
   output logic                       wr_allow,
   output logic                       usb_rd_req,
   output logic [BADDR_NBIT-1:0]      usb_rd_baddr,
   input  logic                       usb_rd_ack,
   input  logic                       usb_rd_done,
   output logic                       ovf_flag,
   input  logic                       ovf_clr,
   output logic [OVF_CNT_NBIT-1:0]    ovf_cnt,
   output logic [1:0]                 dbg_state,
   output logic [2**BADDR_NBIT-1:0]   dbg_full
);

   // USB handshake: usb_rd_req stays high with usb_rd_baddr stable until usb_rd_ack is
   // sampled high; the bank then belongs to the engine until usb_rd_done. Ack outside REQ
   // and done outside BUSY are ignored.

   localparam int NBANK = 2**BADDR_NBIT;
   localparam int NDATA = NBANK - 1;
   localparam logic [BADDR_NBIT-1:0] FIRST_DATA = BADDR_NBIT'(1);
   localparam logic [BADDR_NBIT-1:0] LAST_DATA  = BADDR_NBIT'(NDATA);
   localparam logic [BADDR_NBIT-1:0] LAST_SLOT  = BADDR_NBIT'(NDATA - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_BUSY    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [NBANK-1:0]      full_q, full_d;
   logic                  hs_q, hs_d;
   logic [BADDR_NBIT-1:0] fifo_q [NDATA];
   logic [BADDR_NBIT-1:0] fifo_d [NDATA];
   logic [BADDR_NBIT-1:0] rd_ptr_q, rd_ptr_d;
   logic [BADDR_NBIT-1:0] wr_ptr_q, wr_ptr_d;
   logic [BADDR_NBIT-1:0] cnt_q, cnt_d;
   logic [BADDR_NBIT-1:0] rd_baddr_q, rd_baddr_d;
   logic [BADDR_NBIT-1:0] next_q, next_d;
   logic                  ovf_q, ovf_d;

   logic in_release, in_flight, ovf_evt, eop_ok;
   logic push_hs, push_fifo, pop_hs, pop_fifo;

   // A bank being released may be refilled in that same cycle; only in-flight or queued banks overflow.
   always_comb begin
      in_release = (state_q == S_RELEASE) && (rd_baddr_q == wr_baddr);
      in_flight  = ((state_q == S_REQ) || (state_q == S_BUSY)) && (rd_baddr_q == wr_baddr);
      ovf_evt    = wr_eop && ((full_q[wr_baddr] && !in_release) || in_flight);
      eop_ok     = wr_eop && !ovf_evt;
      push_hs    = eop_ok && (wr_baddr == '0);
      push_fifo  = eop_ok && (wr_baddr != '0);
   end

   always_comb begin
      state_d    = state_q;
      rd_baddr_d = rd_baddr_q;
      full_d     = full_q;
      pop_hs     = 1'b0;
      pop_fifo   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hs_q) begin
               state_d    = S_REQ;
               rd_baddr_d = '0;
               pop_hs     = 1'b1;
            end else if (cnt_q != '0) begin
               state_d    = S_REQ;
               rd_baddr_d = fifo_q[rd_ptr_q];
               pop_fifo   = 1'b1;
            end
         end
         S_REQ:   if (usb_rd_ack)  state_d = S_BUSY;
         S_BUSY:  if (usb_rd_done) state_d = S_RELEASE;
         default: begin
            state_d                = S_IDLE;
            full_d[rd_baddr_q]     = 1'b0;
         end
      endcase
      if (eop_ok) full_d[wr_baddr] = 1'b1;
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_fifo) begin
         fifo_d[wr_ptr_q] = wr_baddr;
         wr_ptr_d         = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_fifo) rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
      case ({push_fifo, pop_fifo})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      hs_d = (hs_q && !pop_hs) || push_hs;
   end

   always_comb begin
      next_d = next_q;
      if (wr_eop && (wr_baddr != '0)) next_d = (wr_baddr == LAST_DATA) ? FIRST_DATA : wr_baddr + 1'b1;
      ovf_d = ovf_q;
      if (ovf_clr)      ovf_d = ovf_evt;
      else if (ovf_evt) ovf_d = 1'b1;
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         full_q     <= '0;
         hs_q       <= 1'b0;
         for (int i = 0; i < NDATA; i++) fifo_q[i] <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         rd_baddr_q <= '0;
         next_q     <= FIRST_DATA;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         full_q     <= full_d;
         hs_q       <= hs_d;
         fifo_q     <= fifo_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         rd_baddr_q <= rd_baddr_d;
         next_q     <= next_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef TX_BANK_SCHED_OVF_CNT_EN
   logic [OVF_CNT_NBIT-1:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_clr)                           ovf_cnt_d = ovf_evt ? OVF_CNT_NBIT'(1) : '0;
      else if (ovf_evt && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt = ovf_cnt_q;
`else
   assign ovf_cnt = '0;
`endif

   assign wr_next_baddr = next_q;
   assign wr_allow      = !full_q[next_q];
   assign usb_rd_req    = (state_q == S_REQ);
   assign usb_rd_baddr  = rd_baddr_q;
   assign ovf_flag      = ovf_q;
   assign dbg_state     = state_q;
   assign dbg_full      = full_q;

endmodule

// File: tb/tb_tx_bank_sched.sv
// Bench for tx_bank_sched: directed scenarios then randomized traffic, checked against a
// bank/queue reference model that acts as both frame writer and USB engine.
module tb_tx_bank_sched;

   localparam int BADDR_NBIT   = 2;
   localparam int OVF_CNT_NBIT = 16;
   localparam int NBANK        = 4;
   localparam int NDATA        = 3;
   localparam int CNT_MAX      = 65535;

   logic                    mclk = 1'b0;
   logic                    rst_n;
   logic                    wr_eop;
   logic [BADDR_NBIT-1:0]   wr_baddr;
   logic [BADDR_NBIT-1:0]   wr_next_baddr;
   logic                    wr_allow;
   logic                    usb_rd_req;
   logic [BADDR_NBIT-1:0]   usb_rd_baddr;
   logic                    usb_rd_ack;
   logic                    usb_rd_done;
   logic                    ovf_flag;
   logic                    ovf_clr;
   logic [OVF_CNT_NBIT-1:0] ovf_cnt;
   logic [1:0]              dbg_state;
   logic [NBANK-1:0]        dbg_full;

   // clock / reset
   always #5 mclk = ~mclk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   tx_bank_sched #(.BADDR_NBIT(BADDR_NBIT), .OVF_CNT_NBIT(OVF_CNT_NBIT)) dut (
      .mclk(mclk), .rst_n(rst_n),
      .wr_eop(wr_eop), .wr_baddr(wr_baddr),
      .wr_next_baddr(wr_next_baddr), .wr_allow(wr_allow),
      .usb_rd_req(usb_rd_req), .usb_rd_baddr(usb_rd_baddr),
      .usb_rd_ack(usb_rd_ack), .usb_rd_done(usb_rd_done),
      .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt),
      .dbg_state(dbg_state), .dbg_full(dbg_full)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model: bank occupancy, pending handshake, data banks in fill order
   bit                    m_full [NBANK];
   int                    m_hs_t;
   logic [BADDR_NBIT-1:0] exp_q [$];
   int                    exp_t_q [$];
   int                    m_next;
   bit                    m_ovf;
   int                    m_cnt;
   int                    phase;      // 0 nothing offered, 1 offered, 2 accepted
   int                    cur_bank;
   bit                    rel_armed;
   int                    rel_bank;
   int                    edge_n = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef TX_BANK_SCHED_OVF_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   function automatic logic [31:0] full_vec();
      logic [31:0] v = 0;
      for (int i = 0; i < NBANK; i++) v[i] = m_full[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NBANK; i++) m_full[i] = 1'b0;
      m_hs_t = -1;
      exp_q.delete();
      exp_t_q.delete();
      m_next = 1;
      m_ovf = 1'b0;
      m_cnt = 0;
      phase = 0;
      cur_bank = 0;
      rel_armed = 1'b0;
      rel_bank = 0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"}, usb_rd_req, 0);
      chk({tag, "_baddr"}, usb_rd_baddr, 0);
      chk({tag, "_next"}, wr_next_baddr, 1);
      chk({tag, "_allow"}, wr_allow, 1);
      chk({tag, "_ovf"}, ovf_flag, 0);
      chk({tag, "_cnt"}, ovf_cnt, 0);
      chk({tag, "_state"}, dbg_state, 0);
      chk({tag, "_full"}, dbg_full, 0);
   endtask

   // An offer made at edge X can only pick banks queued at an earlier edge.
   task automatic check_cycle();
      int exp_b;
      if (phase == 0 && usb_rd_req === 1'b1) begin
         exp_b = -1;
         if (m_hs_t >= 0 && m_hs_t < edge_n) begin
            exp_b = 0;
            m_hs_t = -1;
         end else if (exp_q.size() > 0 && exp_t_q[0] < edge_n) begin
            exp_b = int'(exp_q.pop_front());
            void'(exp_t_q.pop_front());
         end
         chk("offer_bank", usb_rd_baddr, exp_b);
         phase = 1;
         cur_bank = (exp_b < 0) ? int'(usb_rd_baddr) : exp_b;
      end
      chk("usb_rd_req", usb_rd_req, phase == 1);
      if (phase != 0) chk("usb_rd_baddr", usb_rd_baddr, cur_bank);
      chk("wr_next_baddr", wr_next_baddr, m_next);
      chk("wr_allow", wr_allow, !m_full[m_next]);
      chk("ovf_flag", ovf_flag, m_ovf);
      chk("ovf_cnt", ovf_cnt, exp_cnt());
      chk("full", dbg_full, full_vec());
   endtask

   // driver: one clock with the given inputs, model advanced at the edge, outputs checked after
   task automatic tick(input bit eop, input int b, input bit ack, input bit done, input bit clr);
      bit ack_hon, done_hon, rel_now, ovf_now;
      int rel_b;
      wr_eop = eop;
      wr_baddr = BADDR_NBIT'(b);
      usb_rd_ack = ack;
      usb_rd_done = done;
      ovf_clr = clr;
      ack_hon = ack && (phase == 1);
      done_hon = done && (phase == 2);
      rel_now = rel_armed;
      rel_b = rel_bank;
      rel_armed = 1'b0;
      @(posedge mclk);
      edge_n++;
      ovf_now = eop && m_full[b] && !(rel_now && rel_b == b);
      if (rel_now) m_full[rel_b] = 1'b0;
      if (eop && !ovf_now) begin
         m_full[b] = 1'b1;
         if (b == 0) m_hs_t = edge_n;
         else begin
            exp_q.push_back(BADDR_NBIT'(b));
            exp_t_q.push_back(edge_n);
         end
      end
      if (eop && b != 0) m_next = (b == NDATA) ? 1 : b + 1;
      if (clr) begin
         m_ovf = ovf_now;
         m_cnt = ovf_now ? 1 : 0;
      end else if (ovf_now) begin
         m_ovf = 1'b1;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (ack_hon) phase = 2;
      if (done_hon) begin
         phase = 0;
         rel_armed = 1'b1;
         rel_bank = cur_bank;
      end
      @(negedge mclk);
      wr_eop = 1'b0;
      wr_baddr = '0;
      usb_rd_ack = 1'b0;
      usb_rd_done = 1'b0;
      ovf_clr = 1'b0;
      check_cycle();
   endtask

   task automatic serve(input int exp_bank, input int hold);
      int waited = 0;
      while (phase != 1 && waited < 20) begin
         tick(0, 0, 0, 0, 0);
         waited++;
      end
      chk("serve_offered", phase, 1);
      chk("serve_bank", usb_rd_baddr, exp_bank);
      tick(0, 0, 1, 0, 0);
      repeat (hold) tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0);
   endtask

   initial begin
      bit e, a, d, c;
      int b;
      rst_n = 1'b0;
      wr_eop = 1'b0;
      wr_baddr = '0;
      usb_rd_ack = 1'b0;
      usb_rd_done = 1'b0;
      ovf_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge mclk);
      check_reset("rst_init");
      rst_n = 1'b1;
      tick(0, 0, 0, 0, 0);

      // T2 handshake latency and release
      tick(1, 0, 0, 0, 0);
      chk("t2_req_n1", usb_rd_req, 0);
      tick(0, 0, 0, 0, 0);
      chk("t2_req_n2", usb_rd_req, 1);
      chk("t2_baddr", usb_rd_baddr, 0);
      tick(0, 0, 1, 0, 0);
      chk("t2_busy", dbg_state, 2);
      chk("t2_full0_busy", dbg_full[0], 1);
      tick(0, 0, 0, 1, 0);
      chk("t2_release", dbg_state, 3);
      tick(0, 0, 0, 0, 0);
      chk("t2_full0_clr", dbg_full[0], 0);
      chk("t2_idle", dbg_state, 0);

      // T3 priority, fill order, writer ring, turnaround
      tick(1, 3, 0, 0, 0);
      chk("t3_next_a", wr_next_baddr, 1);
      tick(0, 0, 0, 0, 0);
      chk("t3_offer3", usb_rd_baddr, 3);
      tick(0, 0, 1, 0, 0);
      tick(1, 1, 0, 0, 0);
      chk("t3_next_b", wr_next_baddr, 2);
      tick(1, 2, 0, 0, 0);
      chk("t3_next_c", wr_next_baddr, 3);
      tick(1, 0, 0, 0, 0);
      chk("t3_next_d", wr_next_baddr, 3);
      tick(0, 0, 0, 1, 0);
      chk("t3_turn_a", usb_rd_req, 0);
      tick(0, 0, 0, 0, 0);
      chk("t3_turn_b", usb_rd_req, 0);
      tick(0, 0, 0, 0, 0);
      chk("t3_turn_c", usb_rd_req, 1);
      serve(0, 1);
      serve(1, 0);
      serve(2, 2);

      // T1 reset while BUSY
      tick(1, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0);
      chk("t1_busy", dbg_state, 2);
      rst_n = 1'b0;
      #1;
      check_reset("t1");
      model_reset();
      @(posedge mclk);
      @(negedge mclk);
      rst_n = 1'b1;

      // T4 all data banks full, then a dropped frame
      tick(1, 1, 0, 0, 0);
      tick(1, 2, 0, 0, 0);
      tick(1, 3, 0, 0, 0);
      chk("t4_next", wr_next_baddr, 1);
      chk("t4_allow", wr_allow, 0);
      tick(1, 1, 0, 0, 0);
      chk("t4_ovf_flag", ovf_flag, 1);
`ifdef TX_BANK_SCHED_OVF_CNT_EN
      chk("t4_ovf_cnt", ovf_cnt, 1);
`else
      chk("t4_ovf_cnt", ovf_cnt, 0);
`endif
      serve(1, 0);
      serve(2, 0);
      serve(3, 0);
      repeat (6) tick(0, 0, 0, 0, 0);
      chk("t4_no_extra", usb_rd_req, 0);

      // T6 clear
      tick(0, 0, 0, 0, 1);
      chk("t6_clr_flag", ovf_flag, 0);
      chk("t6_clr_cnt", ovf_cnt, 0);

      // T5 refill during the release cycle
      tick(1, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0);
      tick(0, 0, 0, 1, 0);
      chk("t5_release", dbg_state, 3);
      tick(1, 1, 0, 0, 0);
      chk("t5_full1", dbg_full[1], 1);
      chk("t5_no_ovf", ovf_flag, 0);
      serve(1, 0);
      chk("t5_full1_after", dbg_full[1], 0);

      // T6 stray handshakes, clear racing a new overflow
      tick(0, 0, 1, 0, 0);
      chk("t6_ack_idle_state", dbg_state, 0);
      chk("t6_ack_idle_req", usb_rd_req, 0);
      tick(1, 2, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      chk("t6_done_req_state", dbg_state, 1);
      chk("t6_done_req_req", usb_rd_req, 1);
      tick(1, 2, 0, 0, 1);
      chk("t6_race_flag", ovf_flag, 1);
`ifdef TX_BANK_SCHED_OVF_CNT_EN
      chk("t6_race_cnt", ovf_cnt, 1);
`else
      chk("t6_race_cnt", ovf_cnt, 0);
`endif
      tick(0, 0, 0, 0, 1);
      chk("t6_clr2_flag", ovf_flag, 0);
      chk("t6_clr2_cnt", ovf_cnt, 0);
      serve(2, 0);

      // randomized writer / engine traffic
      for (int i = 0; i < 600; i++) begin
         e = ($urandom_range(0, 99) < 30);
         b = ($urandom_range(0, 1) == 1) ? m_next : int'($urandom_range(0, NDATA));
         a = (phase == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         d = (phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         c = ($urandom_range(0, 49) == 0);
         tick(e, b, a, d, c);
      end

      for (int i = 0; i < 100; i++) tick(0, 0, phase == 1, phase == 2, 0);
      chk("drain_queue", exp_q.size() + ((m_hs_t >= 0) ? 1 : 0), 0);
      chk("drain_state", dbg_state, 0);
      chk("drain_full", dbg_full, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
